// File: rtl/ft_pkg.sv
// Shared types and default sizing for the duplicated-core register-file recovery block.
package ft_pkg;

  localparam int unsigned FT_NUM_REGS = 32;
  localparam int unsigned FT_ADDR_W   = 5;
  localparam int unsigned FT_DATA_W   = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HALT    = 2'd1,
    RESTORE = 2'd2,
    RELEASE = 2'd3
  } rec_state_e;

endpackage

// File: rtl/golden_rf.sv
// Golden register file: one write port, two combinational read ports, x0 reads as zero.
module golden_rf
  import ft_pkg::*;
#(
  parameter int unsigned NUM_REGS = FT_NUM_REGS,
  parameter int unsigned ADDR_W   = FT_ADDR_W,
  parameter int unsigned DATA_W   = FT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];

  // x0 is never written, so its entry stays at the reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];

endmodule

// File: rtl/ft_rf_recovery.sv
// Commits agreed writes to the golden file and, on a core mismatch, halts both cores and
// streams the golden contents back. Optional mismatch counter under FT_ERR_COUNT_EN.
module ft_rf_recovery
  import ft_pkg::*;
#(
  parameter int unsigned NUM_REGS  = FT_NUM_REGS,
  parameter int unsigned ADDR_W    = FT_ADDR_W,
  parameter int unsigned DATA_W    = FT_DATA_W
`ifdef FT_ERR_COUNT_EN
  ,
  parameter int unsigned ERR_CNT_W = 8
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] data,
  input  logic              error,
  output logic              halt,
  output logic              resume,
  output logic              rst_we,
  output logic [ADDR_W-1:0] rst_addr,
  output logic [DATA_W-1:0] rst_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy
`ifdef FT_ERR_COUNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_count
`endif
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_REGS - 1);

  rec_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              commit;
  logic [DATA_W-1:0] restore_rd;

  golden_rf #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) u_golden (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (commit),
    .waddr_i   (w_addr),
    .wdata_i   (data),
    .raddr_a_i (ptr_q),
    .rdata_a_o (restore_rd),
    .raddr_b_i (rd_addr),
    .rdata_b_o (rd_data)
  );

  // State register and restore pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state; the pointer stops at the last register instead of wrapping.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (error) state_d = HALT;
      end
      HALT: begin
        ptr_d   = ADDR_W'(1);
        state_d = RESTORE;
      end
      RESTORE: begin
        if (ptr_q == LAST_PTR) begin
          ptr_d   = '0;
          state_d = RELEASE;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs; a mismatch in the same cycle suppresses the commit.
  always_comb begin
    halt     = (state_q != IDLE);
    busy     = (state_q != IDLE);
    resume   = (state_q == RELEASE);
    rst_we   = (state_q == RESTORE);
    rst_addr = (state_q == RESTORE) ? ptr_q : '0;
    rst_data = (state_q == RESTORE) ? restore_rd : '0;
    commit   = (state_q == IDLE) && !error && w_en && (w_addr != '0);
  end

`ifdef FT_ERR_COUNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // Saturating count of recoveries entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if ((state_q == IDLE) && error && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_ft_rf_recovery.sv
// Scoreboard bench for ft_rf_recovery: restore beats and recovery lengths are queued by the
// stimulus and checked by a negedge monitor. Define FT_ERR_COUNT_EN to cover the counter.
module tb_ft_rf_recovery;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        w_en;
  logic [4:0]  w_addr;
  logic [31:0] data;
  logic        error;
  logic        halt, resume, rst_we, busy;
  logic [4:0]  rst_addr;
  logic [31:0] rst_data;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
`ifdef FT_ERR_COUNT_EN
  logic [1:0]  err_count;
`endif

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } rst_beat_t;

  rst_beat_t exp_rst[$];
  int        exp_len[$];
  int        n_pass  = 0;
  int        n_total = 0;
  int        halt_len = 0;
  bit        prev_halt = 1'b0;
  int        resume_cnt = 0;

  always #5 clk = ~clk;

  ft_rf_recovery #(
    .NUM_REGS  (32),
    .ADDR_W    (5),
    .DATA_W    (32)
`ifdef FT_ERR_COUNT_EN
    ,
    .ERR_CNT_W (2)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .w_en      (w_en),
    .w_addr    (w_addr),
    .data      (data),
    .error     (error),
    .halt      (halt),
    .resume    (resume),
    .rst_we    (rst_we),
    .rst_addr  (rst_addr),
    .rst_data  (rst_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy)
`ifdef FT_ERR_COUNT_EN
    ,
    .err_count (err_count)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Monitor: compares every restore beat, recovery length and resume placement.
  always @(negedge clk) begin
    if (!rst_n) begin
      halt_len  = 0;
      prev_halt = 1'b0;
    end else begin
      if (halt) halt_len++;
      chk("busy_eq_halt", 64'(busy), 64'(halt));
      if (rst_we) begin
        if (exp_rst.size() == 0) begin
          chk("unexpected_restore", 64'(rst_addr), 64'hFFFF);
        end else begin
          rst_beat_t e;
          e = exp_rst.pop_front();
          chk("rst_addr", 64'(rst_addr), 64'(e.addr));
          chk("rst_data", 64'(rst_data), 64'(e.data));
        end
      end else begin
        chk("restore_bus_idle", {27'd0, rst_addr, rst_data}, 64'd0);
      end
      if (resume) begin
        resume_cnt++;
        chk("resume_position", 64'(halt_len), 64'd33);
        chk("restore_drained", 64'(exp_rst.size()), 64'd0);
      end
      if (!halt && prev_halt) begin
        if (exp_len.size() == 0) begin
          chk("unexpected_recovery", 64'(halt_len), 64'd0);
        end else begin
          chk("halt_length", 64'(halt_len), 64'(exp_len.pop_front()));
        end
        halt_len = 0;
      end
      prev_halt = halt;
    end
  end

  task automatic wr(input int a, input logic [31:0] d);
    w_en = 1'b1; w_addr = 5'(a); data = d;
    @(posedge clk); #1;
    w_en = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input int a, input logic [31:0] e);
    rd_addr = 5'(a);
    #1;
    chk(nm, 64'(rd_data), 64'(e));
  endtask

  // Pulses error together with a write to x3; optionally toggles inputs during recovery.
  task automatic recover(input bit ident, input bit toggle);
    int n;
    rst_beat_t b;
    for (int a = 1; a < 32; a++) begin
      b.addr = 5'(a);
      b.data = ident ? 32'(a) : 32'd0;
      exp_rst.push_back(b);
    end
    exp_len.push_back(33);
    error = 1'b1; w_en = 1'b1; w_addr = 5'd3; data = 32'hFFFF;
    @(posedge clk); #1;
    error = 1'b0; w_en = 1'b0;
    if (toggle) begin
      for (int i = 0; i < 31; i++) begin
        w_en = i[0]; error = i[1]; w_addr = 5'd7; data = 32'hAAAA_0000 | 32'(i);
        @(posedge clk); #1;
      end
      w_en = 1'b0; error = 1'b0;
    end
    n = 0;
    while (busy && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("recovery_done", 64'(busy), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, n;
    rst_n = 1'b0; w_en = 1'b0; w_addr = '0; data = '0; error = 1'b0; rd_addr = '0;
    #3;
    chk("reset_outputs", {58'd0, halt, resume, rst_we, busy, 2'b00}, 64'd0);
    chk("reset_restore_bus", {27'd0, rst_addr, rst_data}, 64'd0);
    rd_chk("reset_rd_x5", 5, 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    wr(5, 32'hDEADBEEF);
    rd_chk("commit_x5", 5, 32'hDEADBEEF);
    chk("no_halt_after_write", 64'(halt), 64'd0);

    wr(0, 32'h1234);
    rd_chk("x0_is_zero", 0, 32'd0);
    rd_chk("x5_after_x0_write", 5, 32'hDEADBEEF);
    chk("x0_write_no_busy", 64'(busy), 64'd0);

    for (int a = 1; a < 32; a++) wr(a, 32'(a));
    rd_chk("preload_x31", 31, 32'd31);

    r0 = resume_cnt;
    recover(1'b1, 1'b0);
    rd_chk("x3_write_dropped", 3, 32'd3);
    chk("one_resume", 64'(resume_cnt - r0), 64'd1);

    r0 = resume_cnt;
    recover(1'b1, 1'b1);
    rd_chk("x7_ignored_in_restore", 7, 32'd7);
    rd_chk("x3_ignored_in_restore", 3, 32'd3);
    chk("one_resume_toggled", 64'(resume_cnt - r0), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("no_restart", 64'(busy), 64'd0);

    // Reset in the 10th restore beat: nine beats seen, the rest abandoned.
    r0 = resume_cnt;
    for (int a = 1; a < 32; a++) begin
      rst_beat_t b;
      b.addr = 5'(a);
      b.data = 32'(a);
      exp_rst.push_back(b);
    end
    error = 1'b1;
    @(posedge clk); #1;
    error = 1'b0;
    n = 0;
    while (!(rst_we && rst_addr == 5'd10) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reached_beat_10", 64'(rst_addr), 64'd10);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {58'd0, halt, resume, rst_we, busy, 2'b00}, 64'd0);
    chk("async_reset_bus", {27'd0, rst_addr, rst_data}, 64'd0);
    chk("beats_before_reset", 64'(exp_rst.size()), 64'd22);
    exp_rst.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a < 32; a++) rd_chk("cleared_rf", a, 32'd0);
    chk("busy_after_reset", 64'(busy), 64'd0);
    chk("no_resume_on_reset", 64'(resume_cnt - r0), 64'd0);

`ifdef FT_ERR_COUNT_EN
    chk("err_count_reset", 64'(err_count), 64'd0);
    for (int k = 1; k <= 5; k++) begin
      recover(1'b0, 1'b0);
      chk("err_count", 64'(err_count), (k < 3) ? 64'(k) : 64'd3);
    end
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("queues_empty", 64'(exp_rst.size() + exp_len.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ft_rf_recovery.md
# ft_rf_recovery

Downstream stage of the write-port comparator in the duplicated-core register file. It consumes the comparator's agreed write (`w_en`, `w_addr`, `data`) and mismatch flag (`error`). Agreed writes are committed into a golden register file. On a mismatch, a recovery FSM halts both cores, streams the golden contents back into both private register files, and then releases the cores.

## Interface
Parameters:
- `NUM_REGS`, 32: architectural registers; x0 is hard-wired to zero.
- `ADDR_W`, 5: register address width, equal to $clog2(NUM_REGS).
- `DATA_W`, 32: register data width.
- `ERR_CNT_W`, 8: error counter width. Used only when `FT_ERR_COUNT_EN` is defined.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `w_en`  in  1: agreed write enable from comparator.
- `w_addr`  in  ADDR_W: agreed write address from comparator.
- `data`  in  DATA_W: agreed write data from comparator.
- `error`  in  1: comparator mismatch flag.
- `halt`  out  1: stall request to both cores.
- `resume`  out  1: one-cycle restart pulse to both cores.
- `rst_we`  out  1: restore write enable to both private register files.
- `rst_addr`  out  ADDR_W: restore address.
- `rst_data`  out  DATA_W: restore data, equal to golden[rst_addr].
- `rd_addr`  in  ADDR_W: debug read address.
- `rd_data`  out  DATA_W: debug read data, combinational; returns 0 for x0.
- `busy`  out  1: high whenever the FSM is not in IDLE.
- `err_count`  out  ERR_CNT_W: saturating mismatch count. Present only with `FT_ERR_COUNT_EN`.

## Operation
- FSM states: IDLE, HALT, RESTORE, RELEASE.
- IDLE:
  - If `error`=0 and `w_en`=1 and `w_addr`≠0, commit: golden[w_addr] ← data.
  - If `error`=1, do not commit the write that cycle. Go to HALT.
- HALT:
  - Lasts exactly one cycle, which lets the cores' pipelines freeze.
  - Load the restore pointer with 1. Go to RESTORE.
- RESTORE:
  - Each cycle drive `rst_we`=1, `rst_addr`=ptr, `rst_data`=golden[ptr], then increment ptr.
  - After ptr = NUM_REGS-1 is driven, go to RELEASE.
  - x0 is never restored.
- RELEASE:
  - Drive `resume`=1 for one cycle. Go to IDLE.
- `halt` is 1 in HALT, RESTORE and RELEASE.
- `busy` is the same as `halt`.
- While not in IDLE, all `w_en`/`error` inputs are ignored: no commits and no new recovery.
- The restore pointer is ADDR_W wide and must not wrap. The transition to RELEASE is decoded from ptr = NUM_REGS-1.
- `rst_addr` and `rst_data` are 0 whenever `rst_we`=0.

## Timing
- Reset values: all outputs 0, golden file all 0, FSM in IDLE, ptr 0, `err_count` 0.
- Commit latency: a write sampled at edge N is visible on `rd_data` after edge N.
- Recovery sequence, with error sampled at edge N:
  - `halt` rises after edge N.
  - First `rst_we` appears after edge N+1.
  - NUM_REGS-1 restore cycles follow.
  - `resume` is high after edge N+NUM_REGS.
  - `halt` falls after edge N+NUM_REGS+1.
- Total stall is NUM_REGS+1 cycles, i.e. 33 cycles at default parameters.
- Simultaneous `error` and `w_en` in IDLE: error wins and the write is discarded.
- `error` held high across RELEASE→IDLE: a new recovery starts from the first IDLE cycle in which `error` is sampled.
- Reset asserted mid-recovery: immediate return to IDLE with all outputs 0, and the golden file is cleared. No `resume` pulse is issued.

## Configuration
- Macro: `FT_ERR_COUNT_EN`.
- Defined:
  - `err_count` increments on every IDLE→HALT transition.
  - It saturates at 2^ERR_CNT_W-1 and is cleared only by reset.
- Undefined: the `err_count` port and the counter logic are absent. All other behaviour is identical.

## Structure
- Package `ft_pkg` holds:
  - the FSM state enum `rec_state_e` (IDLE, HALT, RESTORE, RELEASE);
  - default-parameter constants `FT_NUM_REGS`, `FT_ADDR_W`, `FT_DATA_W`.
- One sub-module, `golden_rf`:
  - one write port and two combinational read ports (restore and debug);
  - async reset to zero;
  - x0 reads as zero.
- The FSM, restore pointer and counter stay in `ft_rf_recovery`.

## Test plan
- Reset, then write 0xDEADBEEF to x5 with `error`=0 → `rd_data`(x5)=0xDEADBEEF next cycle; `halt`=0.
- Write 0x1234 to x0 → `rd_data`(x0)=0 and no state change.
- Preload x1..x31 with value=addr, then pulse `error` for one cycle with `w_en`=1, x3=0xFFFF:
  - x3 remains 3;
  - `halt` is high for 33 cycles;
  - 31 `rst_we` cycles carry addr/data 1..31 in order;
  - `resume` pulses once on the 32nd cycle after error.
- Keep toggling `w_en`/`error` during RESTORE → golden file unchanged, no restart of the sequence, exactly one `resume` pulse.
- Assert `rst_n` low at the 10th RESTORE cycle → all outputs 0 asynchronously; after release, `rd_data` of every register is 0 and `busy`=0.
- With `FT_ERR_COUNT_EN` and ERR_CNT_W=2, trigger five recoveries → `err_count` reads 1, 2, 3, 3, 3.
